// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the PLL reset / lock supervisor.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_POWERUP   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  localparam int         STATE_W    = 3;
  localparam int         RELOCK_W   = 8;
  localparam logic [7:0] RELOCK_MAX = 8'd255;

  // One spare bit above the largest interval keeps the up-counter from wrapping.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    m = (d > m) ? d : m;
    return $clog2(m) + 32'sd1;
  endfunction

  function automatic int retry_width(input int max_retries);
    return $clog2(max_retries + 32'sd1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// Two-flop synchronizer for a single level signal, with a selectable reset value.
module bit_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Synchronizer chain; first stage may go metastable, second stage is the clean output.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q_r    <= RST_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock supervisor: sequences PLL reset, lock qualification and
// SDRAM power-up hold before releasing the system reset; retries then faults.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int POWERUP_CYCLES      = 5000,
  parameter int MAX_RETRIES         = 4
) (
  input  logic                refclk,
  input  logic                rst,
  output logic                pll_rst,
  input  logic                pll_locked,
  output logic                sys_rst,
  output logic                ready,
  output logic                fault,
  output logic [RELOCK_W-1:0] relock_count,
  output logic [STATE_W-1:0]  state_dbg
);

  localparam int CNT_W   = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                     LOCK_STABLE_CYCLES, POWERUP_CYCLES);
  localparam int RETRY_W = retry_width(MAX_RETRIES);

  // Counter compares are against the last cycle index of each interval.
  localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(32'sd1);
  localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0]   POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 32'sd1);
  localparam logic [RETRY_W-1:0] RETRY_ZERO   = {RETRY_W{1'b0}};
  localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(32'sd1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 32'sd1);

  state_e              state_r;
  state_e              state_nx_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [RETRY_W-1:0]  retry_r;
  logic [RELOCK_W-1:0] relock_r;
  logic                lk_s;
  logic                retry_inc_s;
  logic                relock_inc_s;
  logic                pll_rst_r;
  logic                sys_rst_r;
  logic                ready_r;
  logic                fault_r;

  bit_sync #(
    .RST_VAL(1'b0)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (pll_locked),
    .q  (lk_s)
  );

  // Next-state and event decode.
  always_comb begin
    state_nx_s   = state_r;
    retry_inc_s  = 1'b0;
    relock_inc_s = 1'b0;
    case (state_r)
      ST_RESET_PLL: begin
        if (cnt_r == PLL_RST_LAST) state_nx_s = ST_WAIT_LOCK;
        else                       state_nx_s = ST_RESET_PLL;
      end
      ST_WAIT_LOCK: begin
        if (lk_s) begin
          state_nx_s = ST_STABLE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          retry_inc_s = 1'b1;
          if (retry_r == RETRY_LAST) state_nx_s = ST_FAULT;
          else                       state_nx_s = ST_RESET_PLL;
        end else begin
          state_nx_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!lk_s)                     state_nx_s = ST_WAIT_LOCK;
        else if (cnt_r == STABLE_LAST) state_nx_s = ST_POWERUP;
        else                           state_nx_s = ST_STABLE;
      end
      ST_POWERUP: begin
        if (!lk_s)                      state_nx_s = ST_WAIT_LOCK;
        else if (cnt_r == POWERUP_LAST) state_nx_s = ST_RUN;
        else                            state_nx_s = ST_POWERUP;
      end
      ST_RUN: begin
        if (!lk_s) begin
          relock_inc_s = 1'b1;
          state_nx_s   = ST_RESET_PLL;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_FAULT: state_nx_s = ST_FAULT;
      default:  state_nx_s = ST_RESET_PLL;
    endcase
  end

  // State register and interval counter; the counter restarts on every state change.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r <= ST_RESET_PLL;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nx_s;
      if (state_nx_s != state_r)                          cnt_r <= CNT_ZERO;
      else if ((state_r == ST_RUN) || (state_r == ST_FAULT)) cnt_r <= cnt_r;
      else                                                cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Retry and relock bookkeeping.
  always_ff @(posedge refclk) begin
    if (rst) begin
      retry_r  <= RETRY_ZERO;
      relock_r <= 8'd0;
    end else begin
      if (state_nx_s == ST_RUN) retry_r <= RETRY_ZERO;
      else if (retry_inc_s)     retry_r <= retry_r + RETRY_ONE;
      else                      retry_r <= retry_r;
      if (relock_inc_s && (relock_r != RELOCK_MAX)) relock_r <= relock_r + 8'd1;
      else                                          relock_r <= relock_r;
    end
  end

  // Outputs decoded from the next state so they move with the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst_r <= 1'b1;
      sys_rst_r <= 1'b1;
      ready_r   <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      pll_rst_r <= (state_nx_s == ST_RESET_PLL);
      sys_rst_r <= (state_nx_s != ST_RUN);
      ready_r   <= (state_nx_s == ST_RUN);
      fault_r   <= (state_nx_s == ST_FAULT);
    end
  end

  assign pll_rst      = pll_rst_r;
  assign sys_rst      = sys_rst_r;
  assign ready        = ready_r;
  assign fault        = fault_r;
  assign relock_count = relock_r;
  assign state_dbg    = state_r;

endmodule
